// File: rtl/dispatch_buf.sv
// dispatch_buf
//   FIFO buffer between an in-order instruction source and a 3-entry
//   downstream instruction queue. Each cycle it dispatches up to two
//   instructions, never more than the queue has free slots for.
//
// Parameters
//   DEPTH : buffer entries (power of two, >= 2)
//   WIDTH : instruction payload bits
//
// Ports
//   clock      in   single clock, all state updates on posedge
//   reset      in   synchronous, active-high reset
//   enqValid   in   upstream offers an instruction this cycle
//   enqData    in   offered payload
//   enqReady   out  buffer accepts an instruction this cycle
//   iqValid    in   valid bits of the downstream 3-entry queue
//   flushAll   in   discard all buffered instructions
//   iqLoads    out  dispatch strobes, bit 0 = port 0, bit 1 = port 1
//   disp0Data  out  payload on dispatch port 0 (oldest entry)
//   disp1Data  out  payload on dispatch port 1 (second-oldest entry)
//   occupancy  out  current entry count
//   stallCount out  saturating stall-cycle counter, present only when
//                   DISPATCH_BUF_STALL_STATS_EN is defined
//
// Handshake: an instruction transfers in on a clock edge exactly when
// enqValid && enqReady are both high in the cycle before that edge;
// enqValid may be offered regardless of enqReady, and enqReady depends
// only on registered occupancy and flushAll, never on enqValid or on the
// same-cycle dispatch. An instruction is delivered downstream in any
// cycle its iqLoads bit is high; there is no back-pressure on iqLoads.

module dispatch_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enqValid,
    input  logic [WIDTH-1:0]           enqData,
    output logic                       enqReady,
    input  logic [2:0]                 iqValid,
    input  logic                       flushAll,
    output logic [1:0]                 iqLoads,
    output logic [WIDTH-1:0]           disp0Data,
    output logic [WIDTH-1:0]           disp1Data,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef DISPATCH_BUF_STALL_STATS_EN
    ,
    output logic [15:0]                stallCount
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_plus1;
    logic [PW:0]      occ;
    logic [1:0]       free;
    logic [1:0]       occ_cap;
    logic [1:0]       n;
    logic             accept;

    // Readiness is taken from the registered count only, so a full buffer
    // stays not-ready in the same cycle it dispatches.
    assign enqReady = (occ < FULL) && !flushAll;
    assign accept   = enqValid && enqReady;

    // Dispatch count n = min(occupancy, free queue slots, 2).
    always_comb begin
        free = 2'd0;
        for (int i = 0; i < 3; i++) begin
            free = free + {1'b0, ~iqValid[i]};
        end
        occ_cap = (occ >= (PW+1)'(2)) ? 2'd2 : occ[1:0];
        n = occ_cap;
        if (free < n) begin
            n = free;
        end
        if (flushAll) begin
            n = 2'd0;
        end
    end

    // n is 0..2, so this encoding can never produce 2'b10.
    assign iqLoads    = {n[1], n[1] | n[0]};
    assign head_plus1 = head + PW'(1);
    assign disp0Data  = mem[head];
    assign disp1Data  = mem[head_plus1];
    assign occupancy  = occ;

    // Pointer/count state. A newly written entry is only visible through
    // occ on the following cycle, so there is no enqueue-to-dispatch bypass.
    // For DEPTH=2 the truncating cast of n=2 correctly leaves head in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flushAll) begin
            occ  <= '0;
            head <= tail;
        end else begin
            if (accept) begin
                tail <= tail + PW'(1);
            end
            head <= head + PW'(n);
            occ  <= occ + (PW+1)'(accept) - (PW+1)'(n);
        end
    end

    // Payload storage carries no reset; stale entries are never dispatched
    // because occ gates n.
    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            mem[tail] <= enqData;
        end
    end

`ifdef DISPATCH_BUF_STALL_STATS_EN
    logic [15:0] stall_cnt;

    // Counts cycles where work is waiting but the queue has no room.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((occ != '0) && (free == 2'd0) && !flushAll &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_dispatch_buf.sv
// tb_dispatch_buf
//   Directed bench for dispatch_buf (DEPTH=4, WIDTH=8). A queue-based
//   reference model tracks buffer contents; a compare process checks every
//   output on each negedge, and literal expectations pin key scenarios.

module tb_dispatch_buf;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int PW    = $clog2(DEPTH);

    logic             clock    = 1'b0;
    logic             reset    = 1'b1;
    logic             enqValid = 1'b0;
    logic [WIDTH-1:0] enqData  = '0;
    logic [2:0]       iqValid  = 3'b111;
    logic             flushAll = 1'b0;
    logic             enqReady;
    logic [1:0]       iqLoads;
    logic [WIDTH-1:0] disp0Data;
    logic [WIDTH-1:0] disp1Data;
    logic [PW:0]      occupancy;
`ifdef DISPATCH_BUF_STALL_STATS_EN
    logic [15:0]      stallCount;
`endif

    int total  = 0;
    int passed = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_stall = 0;

    dispatch_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .enqValid  (enqValid),
        .enqData   (enqData),
        .enqReady  (enqReady),
        .iqValid   (iqValid),
        .flushAll  (flushAll),
        .iqLoads   (iqLoads),
        .disp0Data (disp0Data),
        .disp1Data (disp1Data),
        .occupancy (occupancy)
`ifdef DISPATCH_BUF_STALL_STATS_EN
        ,
        .stallCount(stallCount)
`endif
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int free_of(input logic [2:0] v);
        int f = 0;
        for (int i = 0; i < 3; i++) begin
            if (!v[i]) f++;
        end
        return f;
    endfunction

    function automatic int n_of(input int sz, input logic [2:0] v, input logic fl);
        int k;
        if (fl) return 0;
        k = 2;
        if (free_of(v) < k) k = free_of(v);
        if (sz < k) k = sz;
        return k;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clock) begin
        int  sz;
        int  k;
        bit  acc;
        sz = exp_q.size();
        if (reset) begin
            exp_q.delete();
            exp_stall = 0;
        end else if (flushAll) begin
            exp_q.delete();
        end else begin
            k   = n_of(sz, iqValid, 1'b0);
            acc = enqValid && (sz < DEPTH);
            if (sz > 0 && free_of(iqValid) == 0 && exp_stall < 65535) exp_stall++;
            repeat (k) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(enqData);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        int sz;
        int k;
        if (!reset) begin
            sz = exp_q.size();
            k  = n_of(sz, iqValid, flushAll);
            check("enq_ready", 32'(enqReady), 32'(!flushAll && sz < DEPTH));
            check("occupancy", 32'(occupancy), 32'(sz));
            check("iq_loads", 32'(iqLoads), (k == 0) ? 32'd0 : (k == 1) ? 32'd1 : 32'd3);
            if (k >= 1) check("disp0", 32'(disp0Data), 32'(exp_q[0]));
            if (k >= 2) check("disp1", 32'(disp1Data), 32'(exp_q[1]));
`ifdef DISPATCH_BUF_STALL_STATS_EN
            check("stall_count", 32'(stallCount), 32'(exp_stall));
`endif
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic ev, input logic [WIDTH-1:0] d,
                         input logic [2:0] v, input logic fl);
        @(posedge clock);
        #1;
        enqValid = ev;
        enqData  = d;
        iqValid  = v;
        flushAll = fl;
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        reset    = 1'b1;
        enqValid = 1'b1;
        enqData  = 8'hEE;
        iqValid  = 3'b000;
        flushAll = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        enqValid = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] pat [12];

    initial begin
        pat = '{3'b000, 3'b111, 3'b011, 3'b000, 3'b101, 3'b111,
                3'b110, 3'b000, 3'b111, 3'b001, 3'b000, 3'b010};

        reset   = 1'b1;
        iqValid = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_enq_ready", 32'(enqReady), 32'd1);
        check("rst_iq_loads", 32'(iqLoads), 32'd0);

        // Fill A,B,C against a full queue: nothing dispatches.
        drive(1'b1, 8'hA1, 3'b111, 1'b0);
        check("fill_loads_a", 32'(iqLoads), 32'd0);
        drive(1'b1, 8'hB2, 3'b111, 1'b0);
        check("fill_loads_b", 32'(iqLoads), 32'd0);
        drive(1'b1, 8'hC3, 3'b111, 1'b0);
        check("fill_loads_c", 32'(iqLoads), 32'd0);

        // Two free slots: dispatch A and B together.
        drive(1'b0, 8'h00, 3'b010, 1'b0);
        check("abc_occupancy", 32'(occupancy), 32'd3);
        check("abc_enq_ready", 32'(enqReady), 32'd1);
        check("dual_loads", 32'(iqLoads), 32'd3);
        check("dual_disp0", 32'(disp0Data), 32'hA1);
        check("dual_disp1", 32'(disp1Data), 32'hB2);
        drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("after_dual_occ", 32'(occupancy), 32'd1);
        check("after_dual_head", 32'(disp0Data), 32'hC3);

        // Fill to DEPTH; held enqValid adds nothing while full.
        drive(1'b1, 8'hD4, 3'b111, 1'b0);
        drive(1'b1, 8'hE5, 3'b111, 1'b0);
        drive(1'b1, 8'hF6, 3'b111, 1'b0);
        drive(1'b1, 8'h77, 3'b111, 1'b0);
        check("full_enq_ready", 32'(enqReady), 32'd0);
        check("full_occupancy", 32'(occupancy), 32'd4);
        drive(1'b1, 8'h77, 3'b111, 1'b0);
        check("full_hold_occ", 32'(occupancy), 32'd4);
        drive(1'b1, 8'h77, 3'b011, 1'b0);
        check("full_single_loads", 32'(iqLoads), 32'd1);
        check("full_single_disp0", 32'(disp0Data), 32'hC3);
        check("full_single_ready", 32'(enqReady), 32'd0);
        drive(1'b1, 8'h88, 3'b111, 1'b0);
        check("ready_returns", 32'(enqReady), 32'd1);
        drive(1'b0, 8'h00, 3'b000, 1'b0);
        check("drain_loads", 32'(iqLoads), 32'd3);
        check("drain_disp0", 32'(disp0Data), 32'hD4);
        check("drain_disp1", 32'(disp1Data), 32'hE5);

        // occupancy=2, enqueue plus dispatch two with three free slots.
        drive(1'b1, 8'h99, 3'b000, 1'b0);
        check("mix_occ", 32'(occupancy), 32'd2);
        check("mix_loads", 32'(iqLoads), 32'd3);
        check("mix_disp0", 32'(disp0Data), 32'hF6);
        check("mix_disp1", 32'(disp1Data), 32'h88);
        drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("mix_next_occ", 32'(occupancy), 32'd1);
        check("mix_next_head", 32'(disp0Data), 32'h99);
        drive(1'b0, 8'h00, 3'b000, 1'b0);
        check("single_left", 32'(iqLoads), 32'd1);

        // Empty buffer: a new entry is not dispatchable in its own cycle.
        drive(1'b1, 8'hAB, 3'b000, 1'b0);
        check("no_bypass", 32'(iqLoads), 32'd0);
        drive(1'b0, 8'h00, 3'b000, 1'b0);
        check("bypass_next", 32'(disp0Data), 32'hAB);

        // Pointer wrap: more than 2*DEPTH transfers, order held by the model.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h20 + i), pat[i], 1'b0);
        end
        repeat (3) drive(1'b0, 8'h00, 3'b000, 1'b0);
        check("wrap_drained", 32'(occupancy), 32'd0);

        // Flush with enqueue and free slots offered.
        drive(1'b1, 8'h31, 3'b111, 1'b0);
        drive(1'b1, 8'h32, 3'b111, 1'b0);
        drive(1'b1, 8'h33, 3'b111, 1'b0);
        drive(1'b1, 8'hEE, 3'b000, 1'b1);
        check("flush_loads", 32'(iqLoads), 32'd0);
        check("flush_ready", 32'(enqReady), 32'd0);
        check("flush_occ_before", 32'(occupancy), 32'd3);
        drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("flush_occ_after", 32'(occupancy), 32'd0);
        drive(1'b1, 8'h5A, 3'b111, 1'b0);
        drive(1'b0, 8'h00, 3'b110, 1'b0);
        check("post_flush_loads", 32'(iqLoads), 32'd1);
        check("post_flush_disp0", 32'(disp0Data), 32'h5A);

        // Reset in the middle of a fill.
        drive(1'b1, 8'h61, 3'b111, 1'b0);
        drive(1'b1, 8'h62, 3'b111, 1'b0);
        pulse_reset();
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_ready", 32'(enqReady), 32'd1);
        check("midrst_loads", 32'(iqLoads), 32'd0);

`ifdef DISPATCH_BUF_STALL_STATS_EN
        // Second enqueue cycle already sees occupancy 1 with no free slot.
        drive(1'b1, 8'h71, 3'b111, 1'b0);
        drive(1'b1, 8'h72, 3'b111, 1'b0);
        drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("stall_start", 32'(stallCount), 32'd1);
        repeat (4) drive(1'b0, 8'h00, 3'b111, 1'b0);
        drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("stall_five_more", 32'(stallCount), 32'd6);
        repeat (65540) drive(1'b0, 8'h00, 3'b111, 1'b0);
        check("stall_saturate", 32'(stallCount), 32'hFFFF);
`endif

        drive(1'b0, 8'h00, 3'b111, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispatch_buf.md
DISPATCH_BUF -- requirements
Module: dispatch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 8, instruction payload bits.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enqValid  input  1  upstream offers one instruction this cycle.
REQ-006 SHALL have port enqData  input  WIDTH  offered instruction payload.
REQ-007 SHALL have port enqReady  output  1  buffer accepts an instruction this cycle.
REQ-008 SHALL have port iqValid  input  3  current valid bits of the downstream 3-entry instruction queue.
REQ-009 SHALL have port flushAll  input  1  discard all buffered instructions.
REQ-010 SHALL have port iqLoads  output  2  dispatch strobes to the queue; bit 0 = port 0, bit 1 = port 1.
REQ-011 SHALL have port disp0Data  output  WIDTH  payload on dispatch port 0.
REQ-012 SHALL have port disp1Data  output  WIDTH  payload on dispatch port 1.
REQ-013 SHALL have port occupancy  output  log2(DEPTH)+1  current entry count.

Function
REQ-014 SHALL hold instructions in FIFO order with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL drive enqReady = (occupancy < DEPTH) from registered state only, independent of same-cycle dispatch.
REQ-016 SHALL write enqData at tail and increment tail when enqValid & enqReady.
REQ-017 SHALL compute free = number of zero bits in iqValid (0..3).
REQ-018 SHALL compute n = min(occupancy, free, 2) combinationally.
REQ-019 SHALL drive iqLoads = 2'b00 for n=0, 2'b01 for n=1, 2'b11 for n=2; 2'b10 SHALL never occur.
REQ-020 SHALL drive disp0Data = entry[head] and disp1Data = entry[head+1 mod DEPTH] at all times; values are don't-care unless the matching iqLoads bit is set.
REQ-021 SHALL advance head by n and set occupancy_next = occupancy + accepted - n in the same cycle.
REQ-022 SHALL allow enqueue and dispatch in the same cycle, including at occupancy = DEPTH (dispatch only) and occupancy = 0 (enqueue only, no bypass: new entry not dispatchable until next cycle).
REQ-023 SHALL, on flushAll, set occupancy to 0, head = tail, and force iqLoads = 2'b00 that cycle; an enqueue offered that cycle is dropped and enqReady SHALL read 0 while flushAll is high.
REQ-024 SHALL count an instruction as delivered once its iqLoads bit is high; loss due to a same-cycle downstream flush is not this block's concern.
REQ-025 SHALL never dispatch more than one instruction per free queue slot, so the downstream queue never overflows.

Reset
REQ-026 SHALL on reset clear head, tail, occupancy to 0; iqLoads = 2'b00 and enqReady = 1 in the cycle after reset deasserts.
REQ-027 SHALL give reset priority over flushAll, enqueue and dispatch; reset mid-operation discards all contents.
REQ-028 SHALL not reset payload storage.

Configuration
REQ-029 SHALL, when macro DISPATCH_BUF_STALL_STATS_EN is defined, add output stallCount (16 bits): increments on each cycle with occupancy > 0, free = 0 and no flushAll, saturates at 16'hFFFF, cleared by reset.
REQ-030 SHALL, when DISPATCH_BUF_STALL_STATS_EN is undefined, omit the stallCount port and its logic entirely with no change to other behaviour.

Verification
REQ-031 SHALL check: after reset, enqueue A,B,C on 3 cycles with iqValid=3'b111 -> iqLoads=00 throughout, occupancy=3, enqReady=1.
REQ-032 SHALL check: occupancy=3 (A,B,C), iqValid changes to 3'b010 -> iqLoads=11 with disp0Data=A, disp1Data=B; next cycle occupancy=1 and head holds C.
REQ-033 SHALL check: fill to 4 with iqValid=3'b111 -> enqReady=0; enqValid held high adds nothing; iqValid=3'b011 -> iqLoads=01 and enqReady returns to 1 one cycle later.
REQ-034 SHALL check: occupancy=2, enqValid=1, iqValid=3'b000 (free=3) -> n=2, iqLoads=11, next occupancy=1; pointer wrap after 2*DEPTH transfers preserves FIFO order.
REQ-035 SHALL check: occupancy=3 with flushAll=1, enqValid=1, iqValid=3'b000 -> iqLoads=00, enqReady=0, next occupancy=0; reset asserted mid-fill gives identical empty state.
REQ-036 SHALL check, with DISPATCH_BUF_STALL_STATS_EN defined: occupancy=2 and iqValid=3'b111 held 5 cycles -> stallCount=5; preset near 16'hFFFF saturates.
